// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared keypad code constants, entry FSM state encoding and
//               key classification helpers for the keypad calculator.
//               Imported by operand_entry and by the downstream calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Keypad codes: 0-9 are digits, the rest are command keys.
    localparam logic [3:0] KEY_A   = 4'd10;  // add
    localparam logic [3:0] KEY_B   = 4'd11;  // subtract
    localparam logic [3:0] KEY_C   = 4'd12;  // multiply
    localparam logic [3:0] KEY_D   = 4'd13;  // hold
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_EQ  = 4'd15;

    // Width of each operand value as seen by the calculator.
    localparam int OPERAND_W = 7;

    // Operand entry FSM states; the encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        ST_ENTER1 = 2'd0,
        ST_ENTER2 = 2'd1,
        ST_DONE   = 2'd2
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k >= KEY_A) && (k <= KEY_D);
    endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/dec_accum.sv
`default_nettype none
// ============================================================================
// Module      : dec_accum
// Description : Decimal operand accumulator. Holds a 7-bit binary value and
//               a count of decimal digits entered so far.
//   clk, rst   : clock / synchronous active-high reset
//   clear      : zero value and digit count (highest priority)
//   load       : start a fresh operand with digit as its first digit
//   accum      : append digit (value*10+digit) while count < MAX_DIGITS
//   digit      : decimal digit 0-9
//   value      : current operand value
//   has_digit  : at least one digit has been accepted
// Revision    : 1.0 - initial release
// ============================================================================
module dec_accum
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 accum,
    input  logic [3:0]           digit,
    output logic [OPERAND_W-1:0] value,
    output logic                 has_digit
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [OPERAND_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]     count_q, count_d;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear) begin
            value_d = '0;
            count_d = '0;
        end else if (load) begin
            value_d = OPERAND_W'(digit);
            count_d = CNT_W'(1);
        end else if (accum && (count_q < CNT_W'(MAX_DIGITS))) begin
            // Multiply-add is carried at 8 bits and truncated back to the
            // operand width; a full digit count simply drops the new digit.
            value_d = OPERAND_W'(({1'b0, value_q} * 8'd10) + {4'b0000, digit});
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value     = value_q;
    assign has_digit = (count_q != '0);

endmodule : dec_accum
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry
// Description : Keypad operand entry for a two-operand calculator. Collects
//               in1, an operator and in2 from decoded key strobes and hands
//               the completed expression downstream when EQ is pressed.
//   clk, rst   : clock / synchronous active-high reset
//   key        : decoded key code (0-9 digit, 10-13 op, 14 CLR, 15 EQ)
//   key_valid  : one-cycle strobe qualifying key
//   in1, in2   : operands, binary
//   op         : latched operator code (10-13), 0 when none
//   commit     : one-cycle pulse on the cycle ready first rises
//   ready      : expression committed and stable
//   state_dbg  : FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic [6:0] in1,
    output logic [6:0] in2,
    output logic [3:0] op,
    output logic       commit,
    output logic       ready,
    output logic [1:0] state_dbg
);

    entry_state_e state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic         commit_q, commit_d;

    logic clr1, load1, acc1, has1;
    logic clr2, acc2, has2;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        commit_d = 1'b0;
        clr1     = 1'b0;
        load1    = 1'b0;
        acc1     = 1'b0;
        clr2     = 1'b0;
        acc2     = 1'b0;

        if (key_valid) begin
            if (key == KEY_CLR) begin
                clr1    = 1'b1;
                clr2    = 1'b1;
                op_d    = '0;
                state_d = ST_ENTER1;
            end else begin
                unique case (state_q)
                    ST_ENTER1: begin
                        if (is_digit(key)) begin
                            acc1 = 1'b1;
                        end else if (is_operator(key) && has1) begin
                            op_d    = key;
                            state_d = ST_ENTER2;
                        end
                    end
                    ST_ENTER2: begin
                        if (is_digit(key)) begin
                            acc2 = 1'b1;
                        end else if (is_operator(key)) begin
                            // Operator may be changed until in2 has started.
                            if (!has2) begin
                                op_d = key;
                            end
                        end else if ((key == KEY_EQ) && has2) begin
                            state_d  = ST_DONE;
                            commit_d = 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // A digit starts a new expression; everything else
                        // leaves the committed result untouched.
                        if (is_digit(key)) begin
                            load1   = 1'b1;
                            clr2    = 1'b1;
                            op_d    = '0;
                            state_d = ST_ENTER1;
                        end
                    end
                    default: begin
                        state_d = ST_ENTER1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ENTER1;
            op_q     <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            commit_q <= commit_d;
        end
    end

    dec_accum #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clr1),
        .load      (load1),
        .accum     (acc1),
        .digit     (key),
        .value     (in1),
        .has_digit (has1)
    );

    dec_accum #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc2 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clr2),
        .load      (1'b0),
        .accum     (acc2),
        .digit     (key),
        .value     (in2),
        .has_digit (has2)
    );

    assign op        = op_q;
    assign commit    = commit_q;
    assign ready     = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule : operand_entry
`default_nettype wire

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 2, meaning decimal digits accepted per operand (2 gives a maximum of 99, which fits 7 bits).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port key, input, 4 bits: decoded keypad code. 0-9 are digits; 10-13 are operators A/B/C/D (add/sub/mul/hold); 14 is CLR; 15 is EQ.
REQ-005 SHALL have port key_valid, input, 1 bit: one-cycle strobe; key is sampled only when this is high.
REQ-006 SHALL have port in1, output, 7 bits: first operand, binary.
REQ-007 SHALL have port in2, output, 7 bits: second operand, binary.
REQ-008 SHALL have port op, output, 4 bits: latched operator code, 10-13; 0 when none.
REQ-009 SHALL have port commit, output, 1 bit: one-cycle pulse when an expression is completed by EQ.
REQ-010 SHALL have port ready, output, 1 bit: high while in1/in2/op hold a committed expression for the downstream calculator.
REQ-011 SHALL have port state_dbg, output, 2 bits: current FSM state encoding.

Function
REQ-012 SHALL implement FSM states ENTER1=0, ENTER2=1, DONE=2.
REQ-013 SHALL ignore every cycle with key_valid low; all outputs hold.
REQ-014 In ENTER1, a digit d SHALL update in1 to in1*10+d if the operand's digit count is below MAX_DIGITS; otherwise the digit is dropped.
REQ-015 In ENTER1, an operator key SHALL latch op and move to ENTER2 only if at least one in1 digit was entered; otherwise it is ignored.
REQ-016 In ENTER2, a digit SHALL accumulate into in2 under the same rule as REQ-014.
REQ-017 In ENTER2, an operator key with zero in2 digits SHALL replace op; with one or more in2 digits it is ignored.
REQ-018 EQ in ENTER2 with at least one in2 digit SHALL move to DONE and pulse commit for exactly the next cycle; otherwise EQ is ignored.
REQ-019 In ENTER1, EQ SHALL be ignored.
REQ-020 In DONE, ready SHALL be 1 and in1/in2/op SHALL be stable.
REQ-021 In DONE, a digit SHALL clear in1/in2/op and digit counts, load the digit as in1's first digit, and move to ENTER1 (ready falls the same edge).
REQ-022 In DONE, operator and EQ keys SHALL be ignored.
REQ-023 CLR in any state SHALL zero in1, in2, op and both digit counts and go to ENTER1; commit is not pulsed.
REQ-024 Accumulation arithmetic SHALL be performed at 8 bits and truncated to 7; with MAX_DIGITS=2 no overflow is possible.
REQ-025 Key-to-output latency SHALL be one clock; commit SHALL assert in the same cycle ready first rises.

Reset
REQ-026 On rst high at a clock edge, the block SHALL enter ENTER1 with in1=0, in2=0, op=0, commit=0, ready=0 and digit counts 0.
REQ-027 rst SHALL dominate key_valid in the same cycle, including mid-entry and in DONE.

Structure
REQ-028 Shared package calc_pkg SHALL hold key code constants (KEY_A..KEY_D=10..13, KEY_CLR=14, KEY_EQ=15) and the state enum; the downstream calculator SHALL import the same codes.
REQ-029 One sub-module, dec_accum (7-bit value register, digit counter, load/clear/accumulate controls), SHALL be instantiated twice, once per operand.

Verification
REQ-030 Keys 4,2,A,1,7,EQ -> in1=42, op=10, in2=17, commit pulse once, ready=1.
REQ-031 Keys 9,9,9,B,5,EQ -> in1=99 (third 9 dropped), op=11, in2=5, ready=1.
REQ-032 Keys A,3,C,EQ,B,6,EQ -> first A ignored, EQ ignored with no in2 digits, op becomes 11 (replaced), in1=3, in2=6, commit once.
REQ-033 After a committed 12 C 3, key 7 -> ready=0, in1=7, in2=0, op=0, state ENTER1.
REQ-034 Keys 5,A,3 then CLR -> all outputs 0, ENTER1; keys 5,A,3 then rst asserted in the same cycle as key_valid for EQ -> reset values, no commit.
